// File: rtl/div_lane_array.sv
// Multi-lane bit-serial restoring divider array. Lanes are filled in order from a valid/ready
// stream, and the quotients/remainders are reduced with a per-batch mode plus a popcount summary.
module div_lane_array #(
  parameter  int WIDTH     = 32,
  parameter  int NUM_LANES = 4,
  localparam int ONES_W    = $clog2(2*WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_q,
  output logic [WIDTH-1:0]     out_r,
  output logic [ONES_W-1:0]    out_ones,
  output logic [NUM_LANES-1:0] out_dbz
);

  localparam int LC_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {FILL, RUN, OUT} state_t;

  state_t              state;
  logic [LC_W-1:0]     lane_cnt;
  logic [1:0]          mode_q;
  logic                accept;
  logic                release_out;
  logic                all_done;
  logic [NUM_LANES-1:0] load;
  logic [NUM_LANES-1:0] busy;
  logic [NUM_LANES-1:0] done;
  logic [NUM_LANES-1:0] dbz;

  // quo starts as the dividend and shifts quotient bits in from the right as dividend bits leave.
  logic [WIDTH-1:0]    rem      [NUM_LANES];
  logic [WIDTH-1:0]    quo      [NUM_LANES];
  logic [WIDTH-1:0]    dsr      [NUM_LANES];
  logic [CNT_W-1:0]    iter     [NUM_LANES];
  logic [WIDTH:0]      shifted  [NUM_LANES];
  logic [WIDTH-1:0]    diff     [NUM_LANES];
  logic [WIDTH-1:0]    step_rem [NUM_LANES];
  logic [NUM_LANES-1:0] step_q;

  logic [WIDTH-1:0]    q_red;
  logic [WIDTH-1:0]    r_red;
  logic [ONES_W-1:0]   ones;

  assign in_ready    = (state == FILL);
  assign accept      = in_valid && in_ready;
  assign release_out = (state == OUT) && out_ready;
  assign all_done    = &done;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load = '0;
    for (int i = 0; i < NUM_LANES; i++)
      load[i] = accept && (lane_cnt == LC_W'(i));
  end

  // One restoring step: the WIDTH+1 bit partial remainder is compared against the divisor.
  // A zero divisor always "subtracts", which yields q = all ones and r = x.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      shifted[i]  = {rem[i], quo[i][WIDTH-1]};
      diff[i]     = shifted[i][WIDTH-1:0] - dsr[i];
      step_q[i]   = (shifted[i] >= {1'b0, dsr[i]});
      step_rem[i] = step_q[i] ? diff[i] : shifted[i][WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the lane arrays are reset explicitly so an aborted batch leaves no residue.
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rem[i]  <= '0;
        quo[i]  <= '0;
        dsr[i]  <= '0;
        iter[i] <= '0;
      end
      busy <= '0;
      done <= '0;
      dbz  <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (load[i]) begin
          rem[i]  <= '0;
          quo[i]  <= in_x;
          dsr[i]  <= in_y;
          iter[i] <= CNT_W'(WIDTH);
          busy[i] <= 1'b1;
          done[i] <= 1'b0;
          dbz[i]  <= (in_y == '0);
        end else if (busy[i]) begin
          rem[i]  <= step_rem[i];
          quo[i]  <= {quo[i][WIDTH-2:0], step_q[i]};
          iter[i] <= iter[i] - CNT_W'(1);
          if (iter[i] == CNT_W'(1)) begin
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end
        end else if (release_out) begin
          done[i] <= 1'b0;
          dbz[i]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    q_red = quo[0];
    r_red = rem[0];
    for (int i = 1; i < NUM_LANES; i++) begin
      unique case (mode_q)
        2'b00:   begin q_red = q_red | quo[i]; r_red = r_red | rem[i]; end
        2'b01:   begin q_red = q_red & quo[i]; r_red = r_red & rem[i]; end
        2'b10:   begin q_red = q_red ^ quo[i]; r_red = r_red ^ rem[i]; end
        default: ;
      endcase
    end
    ones = '0;
    for (int b = 0; b < WIDTH; b++)
      ones = ones + ONES_W'(q_red[b]) + ONES_W'(r_red[b]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      lane_cnt  <= '0;
      mode_q    <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_ones  <= '0;
      out_dbz   <= '0;
    end else begin
      unique case (state)
        FILL: if (accept) begin
          if (lane_cnt == '0) mode_q <= mode;
          if (lane_cnt == LC_W'(NUM_LANES-1)) begin
            lane_cnt <= '0;
            state    <= RUN;
          end else begin
            lane_cnt <= lane_cnt + LC_W'(1);
          end
        end
        RUN: if (all_done) begin
          out_q     <= q_red;
          out_r     <= r_red;
          out_ones  <= ones;
          out_dbz   <= dbz;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_div_lane_array.sv
// Scoreboard bench for div_lane_array (WIDTH=8, NUM_LANES=4) driven by directed batches
// with hand-computed expected results.
module tb_div_lane_array;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int OW = 5;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [OW-1:0] ones;
    logic [N-1:0]  dbz;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_q;
  logic [W-1:0]  out_r;
  logic [OW-1:0] out_ones;
  logic [N-1:0]  out_dbz;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   last_acc = 0;

  logic [W-1:0] ax [N] = '{8'd100, 8'd200, 8'd50, 8'd255};
  logic [W-1:0] ay [N] = '{8'd7, 8'd9, 8'd5, 8'd16};

  div_lane_array #(.WIDTH(W), .NUM_LANES(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_ones  (out_ones),
    .out_dbz   (out_dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output beat against the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_q=%0d expected=none", out_q);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_q", out_q, mon_e.q);
        check("out_r", out_r, mon_e.r);
        check("out_ones", out_ones, mon_e.ones);
        check("out_dbz", out_dbz, mon_e.dbz);
      end
    end
  end

  // Starts and ends at a negedge; records the edge count of the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                      input int gap);
    int t = 0;
    in_x = x; in_y = y; mode = m; in_valid = 1'b1;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("send_timeout", t, 0);
    @(posedge clk);
    @(negedge clk);
    last_acc = edge_cnt;
    in_valid = 1'b0;
    mode = ~m;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_batch(input logic [W-1:0] y2, input logic [1:0] m0, input logic [1:0] m1,
                           input bit gaps, input int hold, input exp_t e);
    int t = 0;
    exp_q.push_back(e);
    out_ready = (hold == 0);
    for (int i = 0; i < N; i++)
      send(ax[i], (i == 2) ? y2 : ay[i], (i == 0) ? m0 : m1,
           (i == N-1) ? 0 : (gaps ? i+1 : 0));
    while (!out_valid && t < 60) begin @(negedge clk); t++; end
    check("out_valid_rise", out_valid, 1);
    check("latency", edge_cnt - last_acc, W+1);
    for (int c = 0; c < hold; c++) begin
      check("hold_q", out_q, e.q);
      check("hold_r", out_r, e.r);
      check("hold_ones", out_ones, e.ones);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("released_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
  endtask

  initial begin
    int bad;
    // Reset with in_valid toggling: nothing may be accepted or presented.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_x = 8'd3; in_y = 8'd1; mode = 2'b01;
      check("rst_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_q", out_q, 0);
    check("rst_r", out_r, 0);
    check("rst_ones", out_ones, 0);
    check("rst_dbz", out_dbz, 0);
    check("rst_in_ready", in_ready, 1);

    run_batch(8'd5, 2'b00, 2'b00, 1'b0, 0, exp_t'{8'd31,  8'd15, 5'd9,  4'b0000});
    run_batch(8'd5, 2'b01, 2'b01, 1'b0, 0, exp_t'{8'd2,   8'd0,  5'd1,  4'b0000});
    run_batch(8'd5, 2'b10, 2'b10, 1'b0, 0, exp_t'{8'd29,  8'd15, 5'd8,  4'b0000});
    run_batch(8'd0, 2'b11, 2'b11, 1'b0, 0, exp_t'{8'd14,  8'd2,  5'd4,  4'b0100});
    run_batch(8'd0, 2'b00, 2'b00, 1'b0, 0, exp_t'{8'd255, 8'd63, 5'd14, 4'b0100});
    // Gaps of 1..3 cycles, mode changed after lane 0, then 5 cycles of backpressure.
    run_batch(8'd5, 2'b10, 2'b01, 1'b1, 5, exp_t'{8'd29,  8'd15, 5'd8,  4'b0000});

    // Abort a batch with reset three cycles after the final accept.
    for (int i = 0; i < N; i++) send(ax[i], 8'd0, 2'b01, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("abort_no_output", bad, 0);
    run_batch(8'd5, 2'b00, 2'b00, 1'b0, 0, exp_t'{8'd31, 8'd15, 5'd9, 4'b0000});

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_lane_array.md
# div_lane_array

Parametrised multi-lane unsigned divider array with a selectable result-combine mode and a popcount summary. It accepts a batch of NUM_LANES operand pairs over a valid/ready stream, runs one bit-serial restoring divider per lane, and reduces all lane quotients and remainders with a runtime-selected operator (OR, AND, XOR or lane-0 pass-through). It emits the combined quotient, remainder, per-lane divide-by-zero flags and the ones-count of {quotient, remainder} on a valid/ready output. It generalises the fixed 60-stamp, OR-only, 32-bit divider bank used in the top-level datapath.

## Interface
- WIDTH, 32, operand/quotient/remainder width in bits; legal range ≥ 2.
- NUM_LANES, 4, number of divider lanes, equal to operand pairs per batch; legal range ≥ 1.
- ONES_W, $clog2(2*WIDTH+1), width of out_ones; derived, do not override.
- clk  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  array accepting operands.
- in_x  in  WIDTH  dividend, unsigned.
- in_y  in  WIDTH  divisor, unsigned.
- mode  in  2  combine operator: 00 OR, 01 AND, 10 XOR, 11 lane 0 only.
- out_valid  out  1  combined result present.
- out_ready  in  1  consumer accepts result.
- out_q  out  WIDTH  combined quotient.
- out_r  out  WIDTH  combined remainder.
- out_ones  out  ONES_W  popcount of {out_q, out_r}.
- out_dbz  out  NUM_LANES  bit i set when lane i had divisor 0.

## Operation
- State machine has three states. FILL is the reset state. RUN and OUT follow in order, and OUT returns to FILL.
- FILL:
  - in_ready=1.
  - Each in_valid&in_ready edge loads the pair into lane lane_cnt, starts that lane, and increments lane_cnt.
  - Lanes are filled strictly in order 0..NUM_LANES-1.
  - mode is sampled on the edge accepting lane 0 and held for the batch. Later changes to mode are ignored until the next batch.
  - The edge accepting lane NUM_LANES-1 moves the FSM to RUN and clears lane_cnt.
- Each lane runs a restoring division:
  - Partial remainder is WIDTH+1 bits.
  - Each cycle the next dividend MSB is shifted in, the divisor is trial-subtracted, and one quotient bit is produced.
  - Exactly WIDTH iteration cycles follow the load edge, independent of operand values.
  - After finishing, the lane holds q and r and raises its done flag.
- Divide by zero: q = all ones, r = x, and the lane's dbz bit is set. Latency is unchanged.
- RUN: when all done flags are 1, the next edge registers the outputs and the FSM moves to OUT.
  - out_q and out_r take the reduction over lanes 0..NUM_LANES-1 using the sampled mode. Mode 11 takes lane 0's values.
  - out_ones = popcount({out_q, out_r}), registered on the same edge.
  - out_dbz is taken from the lane flags.
- OUT:
  - out_valid=1. All outputs are held stable until out_valid&out_ready.
  - That edge clears out_valid and the done/dbz flags and moves the FSM to FILL.
  - in_ready is 1 from the following cycle. There is no same-cycle bypass.
- in_ready=0 in RUN and OUT. in_valid is ignored there.
- NUM_LANES=1: the FSM goes from FILL to RUN on the first accept, and every mode equals lane 0's result.

## Timing
- Reset (asynchronous, immediate):
  - state=FILL, lane_cnt=0, in_ready=1 (combinational from state).
  - out_valid=0, out_q=0, out_r=0, out_ones=0, out_dbz=0.
  - All lane registers and flags are cleared.
- Reset asserted mid-FILL, RUN or OUT aborts the batch. No partial result is ever presented afterward.
- Latency: final operand accepted at edge k. Lane NUM_LANES-1 iterates on edges k+1..k+WIDTH. Outputs are registered and out_valid rises at edge k+WIDTH+1.
- Earlier lanes finish earlier and wait. Gaps in in_valid during FILL only delay edge k.
- Throughput: at most one batch per NUM_LANES+WIDTH+2 cycles with out_ready held high.

## Test plan
All scenarios use WIDTH=8, NUM_LANES=4, with batch A = (100,7),(200,9),(50,5),(255,16). Per-lane results are q = 14, 22, 10, 15 and r = 2, 2, 0, 15.
- Reset with in_valid toggling → out_valid=0, all outputs 0, in_ready=1 in the cycle after reset_n rises; no accept occurs while reset_n=0.
- Batch A, mode 00 → out_q=31, out_r=15, out_ones=9, out_dbz=0000; out_valid rises exactly 9 edges after the 4th accept.
- Batch A, mode 01 → out_q=2, out_r=0, out_ones=1. Batch A, mode 10 → out_q=29, out_r=15, out_ones=8.
- Batch A with lane 2 changed to (50,0), mode 11 → out_q=14, out_r=2, out_ones=4, out_dbz=0100. Same batch with mode 00 → out_q=0xFF, out_r=0x3F, out_ones=14.
- Backpressure and mode hold:
  - out_ready=0 for 5 cycles in OUT → outputs bit-stable and in_ready=0 throughout.
  - out_ready=1 → out_valid=0 next cycle and in_ready=1.
  - in_valid gaps of 1–3 cycles between beats, with mode changed after lane 0 is accepted → results still match the mode sampled at lane 0.
- reset_n pulsed low 3 cycles after the 4th accept → out_valid stays 0. A new batch A in mode 00 after release → out_q=31, out_r=15 with no residue from the aborted batch.
